// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receiver: start detect, bit timing from the edge/bit counter,
// sampler/deserializer/checker strobes and per-frame valid/error reporting.
module uart_rx_fsm #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [3:0]                bit_cnt,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      cnt_enable,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [PRESCALE_WIDTH-1:0] One = PRESCALE_WIDTH'(1);

    logic [2:0]                state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;

    logic [PRESCALE_WIDTH-1:0] half, h_m1, h_p1, h_p2, h_p3, ps_m1;
    logic                      end_bit, at_strobe, at_result, counting;

    assign half      = ps_q >> 1;
    assign h_m1      = half - One;
    assign h_p1      = half + One;
    assign h_p2      = h_p1 + One;
    assign h_p3      = h_p2 + One;
    assign ps_m1     = ps_q - One;
    assign end_bit   = (edge_cnt == ps_m1);
    assign at_strobe = (edge_cnt == h_p2);
    assign at_result = (edge_cnt == h_p3);
    assign counting  = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                    ps_d    = Prescale;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            START: begin
                // A glitch read on the final edge of the start bit still wins over E.
                if (at_result && strt_glitch) begin
                    state_d = IDLE;
                end else if (end_bit) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (end_bit && (bit_cnt == 4'd8)) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_result) begin
                    perr_d = perr_q | par_err;
                end
                if (end_bit) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_result) begin
                    serr_d = serr_q | stp_err;
                end
                if (end_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!RX_IN) begin
                    state_d = START;
                    ps_d    = Prescale;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_enable  = counting;
        dat_samp_en = counting && ((edge_cnt == h_m1) || (edge_cnt == half) ||
                                   (edge_cnt == h_p1));
        strt_chk_en = (state_q == START) && at_strobe;
        deser_en    = (state_q == DATA) && at_strobe;
        par_chk_en  = (state_q == PARITY) && at_strobe;
        stp_chk_en  = (state_q == STOP) && at_strobe;
        data_valid  = (state_q == DONE) && !(perr_q | serr_q);
        frame_err   = (state_q == DONE) && (perr_q | serr_q);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            ps_q    <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter and the checkers around the FSM and
// compares every cycle's outputs with a timeline derived from bit index and edge position.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [5:0] edge_cnt = 6'd0;
    logic [3:0] bit_cnt = 4'd0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_err;

    logic [5:0] cnt_ps = 6'd8;
    logic       inj_glitch = 1'b0;
    logic       inj_perr = 1'b0;
    logic       inj_serr = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] obs[$];

    uart_rx_fsm #(.PRESCALE_WIDTH(6)) dut (
        .CLK(clk), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Edge/bit counter model: cleared whenever the FSM drops cnt_enable.
    always @(posedge clk) begin
        if (!cnt_enable) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == cnt_ps - 6'd1) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    // Checker models: result valid for one cycle after the enable.
    always @(posedge clk) begin
        strt_glitch <= strt_chk_en & inj_glitch;
        par_err     <= par_chk_en & inj_perr;
        stp_err     <= stp_chk_en & inj_serr;
    end

    // Expected {cnt_en, samp, deser, strt, par, stp, valid, ferr} for cycle c after start detect.
    function automatic logic [7:0] exp_vec(int c, int ps, bit par, bit g, bit pe, bit se,
                                           int rst_at);
        int h  = ps / 2;
        int nb = par ? 11 : 10;
        int b  = c / ps;
        int e  = c % ps;
        logic [7:0] v = 8'h00;
        bit cnt, done, errs;
        if (rst_at >= 0 && c > rst_at) return 8'h00;
        cnt  = g ? (c <= h + 3) : (c < nb * ps);
        done = !g && (c == nb * ps);
        if (cnt) begin
            v[7] = 1'b1;
            v[6] = (e >= h - 1) && (e <= h + 1);
            if (e == h + 2) begin
                if (b == 0)           v[4] = 1'b1;
                else if (b <= 8)      v[5] = 1'b1;
                else if (b == nb - 1) v[2] = 1'b1;
                else                  v[3] = 1'b1;
            end
        end
        if (done) begin
            errs = (par & pe) | se;
            v[1] = !errs;
            v[0] = errs;
        end
        return v;
    endfunction

    function automatic logic line_val(int c, int ps, bit par, bit g, bit chain_next, int rst_at,
                                      logic [7:0] data);
        int h  = ps / 2;
        int nb = par ? 11 : 10;
        int b  = c / ps;
        if (rst_at >= 0 && c > rst_at) return 1'b1;
        if (g && c > h + 3) return 1'b1;
        if (c >= nb * ps) return (c == nb * ps && chain_next) ? 1'b0 : 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (b == 9 && par) return ^data;
        return 1'b1;
    endfunction

    // Drives one frame from the current negedge and records one output vector per cycle.
    task automatic run_frame(input int ps, input bit par, input bit g, input bit pe, input bit se,
                             input bit chain_next, input int ps_chg_at, input int rst_at,
                             input logic [7:0] data, output int total);
        int h  = ps / 2;
        int nb = par ? 11 : 10;
        if (g)                total = h + 5;
        else if (rst_at >= 0) total = rst_at + 4;
        else if (chain_next)  total = nb * ps + 1;
        else                  total = nb * ps + 2;
        obs.delete();
        Prescale   = 6'(ps);
        cnt_ps     = 6'(ps);
        PAR_EN     = par;
        inj_glitch = g;
        inj_perr   = pe;
        inj_serr   = se;
        RX_IN      = 1'b0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            obs.push_back({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                           stp_chk_en, data_valid, frame_err});
            RX_IN = line_val(c + 1, ps, par, g, chain_next, rst_at, data);
            if (c + 1 == ps_chg_at) Prescale = 6'd8;
            RST = (c == rst_at) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset();
        RST   = 1'b0;
        RX_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                 data_valid, frame_err} !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %b exp 00000000", i,
                         {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                          stp_chk_en, data_valid, frame_err});
            end
        end
        RX_IN = 1'b1;
        RST   = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cnt_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 0", cnt_enable);
        end
    endtask

    task automatic test_clean_p8();
        int total, nde, dv_at;
        logic [7:0] e;
        nde   = 0;
        dv_at = -1;
        run_frame(8, 0, 0, 0, 0, 0, -1, -1, 8'hA5, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 8, 0, 0, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL clean_p8 cyc %0d got %b exp %b", c, obs[c], e);
            end
            if (obs[c][5]) nde++;
            if (obs[c][1]) dv_at = c;
        end
        checks++;
        if (nde != 8) begin
            errors++;
            $display("FAIL clean_p8_deser_count got %0d exp 8", nde);
        end
        // START entered one cycle after the line is seen low, so valid lands 81 after detect.
        checks++;
        if (dv_at + 1 != 81) begin
            errors++;
            $display("FAIL clean_p8_valid_latency got %0d exp 81", dv_at + 1);
        end
    endtask

    task automatic test_parity_err();
        int total, pc_at;
        logic [7:0] e;
        pc_at = -1;
        run_frame(16, 1, 0, 1, 0, 0, -1, -1, 8'h3C, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 1, 0, 1, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL parity_err cyc %0d got %b exp %b", c, obs[c], e);
            end
            if (obs[c][3]) pc_at = c;
        end
        checks++;
        if (pc_at != 9 * 16 + 10) begin
            errors++;
            $display("FAIL parity_chk_pos got %0d exp %0d", pc_at, 9 * 16 + 10);
        end
        checks++;
        if (obs[176] !== 8'b0000_0001) begin
            errors++;
            $display("FAIL parity_done got %b exp 00000001", obs[176]);
        end
    endtask

    task automatic test_glitch();
        int total;
        logic [7:0] e;
        run_frame(16, 0, 1, 0, 0, 0, -1, -1, 8'hFF, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 0, 1, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL glitch cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
        checks++;
        if (obs[12][7] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_cnt_off got %b exp 0", obs[12][7]);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        logic [7:0] e;
        run_frame(8, 1, 0, 1, 1, 1, -1, -1, 8'h5A, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 8, 1, 0, 1, 1, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL b2b_first cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
        run_frame(16, 1, 0, 0, 0, 0, -1, -1, 8'hC3, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 1, 0, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL b2b_second cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
    endtask

    task automatic test_prescale_change();
        int total;
        logic [7:0] e;
        run_frame(16, 0, 0, 0, 0, 0, 40, -1, 8'h81, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 0, 0, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL ps_change cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
        run_frame(8, 0, 0, 0, 0, 0, -1, -1, 8'h7E, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 8, 0, 0, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL ps_next_frame cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int total;
        logic [7:0] e;
        run_frame(16, 1, 0, 0, 0, 0, -1, 4 * 16 + 5, 8'h96, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 1, 0, 0, 0, 4 * 16 + 5);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL rst_mid cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
        run_frame(16, 1, 0, 0, 0, 0, -1, -1, 8'h69, total);
        for (int c = 0; c < total; c++) begin
            e = exp_vec(c, 16, 1, 0, 0, 0, -1);
            checks++;
            if (obs[c] !== e) begin
                errors++;
                $display("FAIL rst_recover cyc %0d got %b exp %b", c, obs[c], e);
            end
        end
    endtask

    task automatic test_random();
        int total, ps;
        bit par, g, pe, se, chain, prev_chain;
        logic [7:0] data, e;
        prev_chain = 1'b0;
        for (int f = 0; f < 10; f++) begin
            ps    = 8 << $urandom_range(0, 2);
            par   = 1'($urandom);
            g     = ($urandom_range(0, 4) == 0);
            pe    = 1'($urandom);
            se    = ($urandom_range(0, 3) == 0);
            chain = !g && (f != 9) && 1'($urandom);
            data  = 8'($urandom);
            if (!prev_chain) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            run_frame(ps, par, g, pe, se, chain, -1, -1, data, total);
            for (int c = 0; c < total; c++) begin
                e = exp_vec(c, ps, par, g, pe, se, -1);
                checks++;
                if (obs[c] !== e) begin
                    errors++;
                    $display("FAIL random f%0d ps%0d par%0d cyc %0d got %b exp %b",
                             f, ps, par, c, obs[c], e);
                end
            end
            prev_chain = chain;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_p8();
        test_parity_err();
        test_glitch();
        test_back_to_back();
        test_prescale_change();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
